// File: rtl/imu_spi_seq.sv
// IMU command sequencer: power-up init writes, then a two-byte sample
// read per data-ready interrupt, driving the SPI monarch handshake.
module imu_spi_seq #(
    parameter logic [15:0] STARTUP_CYC = 16'hFFFF,
    parameter logic [15:0] INIT_CMD0   = 16'h0D02,
    parameter logic [15:0] INIT_CMD1   = 16'h1062,
    parameter logic [6:0]  RD_ADDR_L   = 7'h22,
    parameter logic [6:0]  RD_ADDR_H   = 7'h23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        clr_ovr,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] wt_data,
    output logic        ready,
    output logic [15:0] sample,
    output logic        vld,
    output logic        ovr
);

    typedef enum logic [1:0] {
        S_STARTUP = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_IDLE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [1:0]  w_nxt_idx;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic        r_wrt;
    logic [15:0] r_wt_data;
    logic        r_ready;
    logic [7:0]  r_low;
    logic [15:0] r_sample;
    logic        r_vld;
    logic        r_ovr;
    logic        w_int_rise;
    logic        w_cap_lo;
    logic        w_cap_hi;
    logic        w_set_rdy;
    logic        w_ovr_set;
    logic [15:0] w_cmd;
    logic        w_unused;

    assign w_unused   = ^rd_data[15:8];
    assign w_int_rise = r_s2 & ~r_s3;
    // A new edge during a read in progress is dropped and flagged.
    assign w_ovr_set  = w_int_rise & r_idx[1] &
                        ((r_state == S_ISSUE) | (r_state == S_WAIT));

    always_comb begin
        w_nxt     = r_state;
        w_nxt_idx = r_idx;
        w_cap_lo  = 1'b0;
        w_cap_hi  = 1'b0;
        w_set_rdy = 1'b0;
        case (r_state)
            S_STARTUP: begin
                if (r_cnt == STARTUP_CYC - 16'd1) begin
                    w_nxt     = S_ISSUE;
                    w_nxt_idx = 2'd0;
                end
            end
            S_ISSUE: w_nxt = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    case (r_idx)
                        2'd0: begin
                            w_nxt_idx = 2'd1;
                            w_nxt     = S_ISSUE;
                        end
                        2'd1: begin
                            w_set_rdy = 1'b1;
                            w_nxt     = S_IDLE;
                        end
                        2'd2: begin
                            w_cap_lo  = 1'b1;
                            w_nxt_idx = 2'd3;
                            w_nxt     = S_ISSUE;
                        end
                        default: begin
                            w_cap_hi  = 1'b1;
                            w_nxt     = S_IDLE;
                        end
                    endcase
                end
            end
            S_IDLE: begin
                if (w_int_rise) begin
                    w_nxt_idx = 2'd2;
                    w_nxt     = S_ISSUE;
                end
            end
            default: begin
                w_nxt     = S_STARTUP;
                w_nxt_idx = 2'd0;
            end
        endcase
    end

    always_comb begin
        case (w_nxt_idx)
            2'd0:    w_cmd = INIT_CMD0;
            2'd1:    w_cmd = INIT_CMD1;
            2'd2:    w_cmd = {1'b1, RD_ADDR_L, 8'h00};
            default: w_cmd = {1'b1, RD_ADDR_H, 8'h00};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_STARTUP;
            r_cnt     <= 16'h0000;
            r_idx     <= 2'd0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_wrt     <= 1'b0;
            r_wt_data <= 16'h0000;
            r_ready   <= 1'b0;
            r_low     <= 8'h00;
            r_sample  <= 16'h0000;
            r_vld     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_s1    <= INT;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_nxt;
            r_idx   <= w_nxt_idx;
            r_cnt   <= (r_state == S_STARTUP) ? r_cnt + 16'd1 : 16'h0000;
            // Registered start pulse: high exactly while in ISSUE.
            r_wrt   <= (w_nxt == S_ISSUE);
            if (w_nxt == S_ISSUE)
                r_wt_data <= w_cmd;
            if (w_set_rdy)
                r_ready <= 1'b1;
            if (w_cap_lo)
                r_low <= rd_data[7:0];
            if (w_cap_hi)
                r_sample <= {rd_data[7:0], r_low};
            r_vld <= w_cap_hi;
            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (clr_ovr)
                r_ovr <= 1'b0;
        end
    end

    assign wrt     = r_wrt;
    assign wt_data = r_wt_data;
    assign ready   = r_ready;
    assign sample  = r_sample;
    assign vld     = r_vld;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_imu_spi_seq.sv
// Bench for imu_spi_seq: SPI monarch model, scoreboard queues for
// commands and samples, randomized reads, overrun and reset cases.
module tb_imu_spi_seq;

    localparam int SCYC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        clr_ovr = 1'b0;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] wt_data;
    logic        ready;
    logic [15:0] sample;
    logic        vld;
    logic        ovr;

    always #5 clk = ~clk;

    imu_spi_seq #(.STARTUP_CYC(16'd8)) dut (
        .clk(clk), .rst(rst), .INT(INT), .clr_ovr(clr_ovr),
        .done(done), .rd_data(rd_data), .wrt(wrt), .wt_data(wt_data),
        .ready(ready), .sample(sample), .vld(vld), .ovr(ovr)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SPI monarch model: clears done when it samples wrt, raises it
    // lat clocks later; returns the byte the addressed register holds.
    int         lat = 40;
    int         mcnt;
    logic [7:0] lo_b = 8'h00;
    logic [7:0] hi_b = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            rd_data <= 16'h0000;
            mcnt    <= 0;
        end else if (wrt) begin
            done <= 1'b0;
            mcnt <= lat;
            if (wt_data == 16'hA200)
                rd_data <= {8'($urandom), lo_b};
            else if (wt_data == 16'hA300)
                rd_data <= {8'($urandom), hi_b};
            else
                rd_data <= 16'($urandom);
        end else if (mcnt == 1) begin
            done <= 1'b1;
            mcnt <= 0;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end
    end

    logic [15:0] exp_cmd[$];
    logic [15:0] exp_smp[$];
    int   cyc = 0;
    int   wrt_cnt = 0;
    int   vld_cnt = 0;
    int   last_cyc = 0;
    logic pair_ok = 1'b0;
    logic prev_vld = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pair_ok  = 1'b0;
            prev_vld = 1'b0;
        end else begin
            if (wrt) begin
                wrt_cnt++;
                if (exp_cmd.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wrt: wt_data %h, none expected",
                             wt_data);
                end else begin
                    chk("wt_data", wt_data, exp_cmd.pop_front());
                end
                if (pair_ok && (wt_data == 16'h1062 || wt_data == 16'hA300))
                    chk("fresh_done_gap", cyc - last_cyc, lat + 2);
                pair_ok  = (wt_data == 16'h0D02 || wt_data == 16'hA200);
                last_cyc = cyc;
            end
            if (vld) begin
                vld_cnt++;
                chk("vld_single", prev_vld, 1'b0);
                if (exp_smp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_vld: sample %h", sample);
                end else begin
                    chk("sample", sample, exp_smp.pop_front());
                end
            end
            prev_vld = vld;
        end
    end

    task automatic wait_first_wrt();
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (wrt) break;
        end
        chk("first_wrt_delay", n, SCYC);
    endtask

    task automatic wait_ready();
        int k;
        int dn;
        k  = 0;
        dn = 0;
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
            if (wrt) dn = 0;
            else if (done && !ready) dn++;
        end
        chk("ready_seen", ready, 1'b1);
        chk("ready_after_done", dn, 1);
    endtask

    task automatic wait_cmd(input logic [15:0] c);
        int k;
        k = 0;
        while (!(wrt && wt_data == c) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_seen", wt_data, c);
    endtask

    task automatic wait_vld(input int v0);
        int k;
        k = 0;
        while (vld_cnt == v0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("one_sample", vld_cnt - v0, 1);
    endtask

    task automatic expect_read(input logic [7:0] lo, input logic [7:0] hi);
        lo_b = lo;
        hi_b = hi;
        exp_cmd.push_back(16'hA200);
        exp_cmd.push_back(16'hA300);
        exp_smp.push_back({hi, lo});
    endtask

    task automatic do_read(input logic [7:0] lo, input logic [7:0] hi);
        int v0;
        v0 = vld_cnt;
        expect_read(lo, hi);
        INT = 1'b1;
        wait_vld(v0);
        INT = 1'b0;
        repeat (4) @(negedge clk);
        chk("sample_hold", sample, {hi, lo});
        chk("ovr_after_read", ovr, 1'b0);
    endtask

    initial begin
        int v0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wrt", wrt, 1'b0);
        chk("rst_wt_data", wt_data, 16'h0000);
        chk("rst_ready", ready, 1'b0);
        chk("rst_sample", sample, 16'h0000);

        // Power-up with INT toggling during startup and init
        lat = 40;
        wrt_cnt = 0;
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1062);
        rst = 1'b0;
        fork
            begin
                int k;
                k = 0;
                while (wrt_cnt < 2 && k < 400) begin
                    @(negedge clk);
                    INT = 1'($urandom);
                    k++;
                end
                INT = 1'b0;
            end
            wait_first_wrt();
        join
        wait_ready();
        repeat (6) @(negedge clk);
        chk("init_wrt_count", wrt_cnt, 2);
        chk("init_ovr", ovr, 1'b0);
        chk("init_vld_count", vld_cnt, 0);

        // First read runs against the stale done left high in IDLE
        chk("stale_done_high", done, 1'b1);
        do_read(8'hA5, 8'h3C);
        chk("first_sample", sample, 16'h3CA5);

        for (int i = 0; i < 8; i++) begin
            lat = $urandom_range(1, 20);
            do_read(8'($urandom), 8'($urandom));
        end

        // Overrun: new INT edges while the high-byte read is in WAIT
        lat = 40;
        v0 = vld_cnt;
        expect_read(8'($urandom), 8'($urandom));
        INT = 1'b1;
        wait_cmd(16'hA300);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_set", ovr, 1'b1);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_set_wins", ovr, 1'b1);
        wait_vld(v0);
        repeat (6) @(negedge clk);
        chk("ovr_sample_once", vld_cnt - v0, 1);
        chk("ovr_sticky", ovr, 1'b1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_cleared", ovr, 1'b0);
        INT = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of the low-byte read
        expect_read(8'h11, 8'h22);
        INT = 1'b1;
        wait_cmd(16'hA200);
        repeat (5) @(negedge clk);
        INT = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wrt", wrt, 1'b0);
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_sample", sample, 16'h0000);
        chk("mid_rst_vld", vld, 1'b0);
        chk("mid_rst_wt_data", wt_data, 16'h0000);
        exp_cmd.delete();
        exp_smp.delete();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1062);
        repeat (3) @(negedge clk);
        wrt_cnt = 0;
        rst = 1'b0;
        wait_first_wrt();
        wait_ready();
        repeat (4) @(negedge clk);
        chk("reinit_wrt_count", wrt_cnt, 2);
        do_read(8'h5A, 8'hC3);

        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("smp_queue_empty", exp_smp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imu_spi_seq.md
Name: imu_spi_seq

Overview:
- Command sequencer that sits directly upstream of the SPI monarch and owns its wrt/wt_data/done/rd_data handshake.
- After a power-up settle delay it issues two configuration writes to an inertial sensor, then becomes ready.
- On each sensor data-ready interrupt it performs two 16-bit read transactions (low byte, then high byte) and presents the assembled 16-bit sample with a one-cycle valid strobe.

Parameters:
- STARTUP_CYC, 16'hFFFF: clocks to wait after reset before the first transaction (16-bit counter).
- INIT_CMD0, 16'h0D02: first configuration word, sent verbatim.
- INIT_CMD1, 16'h1062: second configuration word, sent verbatim.
- RD_ADDR_L, 7'h22: register address of the sample low byte.
- RD_ADDR_H, 7'h23: register address of the sample high byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- INT  input  1  sensor data-ready, asynchronous to clk.
- clr_ovr  input  1  clears the ovr flag.
- done  input  1  from SPI monarch; high when the last transaction is complete; cleared by the monarch on the edge that samples wrt.
- rd_data  input  16  from SPI monarch; read data is rd_data[7:0].
- wrt  output  1  to SPI monarch; one-cycle start pulse, registered.
- wt_data  output  16  to SPI monarch; command word, registered, stable while wrt is high.
- ready  output  1  high once both init writes have completed.
- sample  output  16  last assembled sample {high byte, low byte}.
- vld  output  1  one-cycle strobe when sample updates.
- ovr  output  1  sticky overrun flag.

Behaviour:
- Reset (async, rst=1): state=STARTUP; wait counter=0; cmd_idx=0; wrt=0; wt_data=16'h0000; ready=0; sample=16'h0000; vld=0; ovr=0; INT synchronizer flops=0.
- Read command format: {1'b1, addr[6:0], 8'h00}. Bit 15 = read. Init words are sent unmodified.
- INT path:
  - INT passes through a 2-flop synchronizer plus one history flop.
  - int_rise = sync2 & ~sync3, so a rising edge is seen 3 clocks after INT rises.
  - Level-high INT with no new edge does not retrigger.
- States:
  - STARTUP: counter increments each clock. When counter == STARTUP_CYC-1, go to ISSUE with cmd_idx=0.
  - ISSUE (one cycle): wrt=1; wt_data = cmd[cmd_idx], where cmd[0]=INIT_CMD0, cmd[1]=INIT_CMD1, cmd[2]=read RD_ADDR_L, cmd[3]=read RD_ADDR_H. Go to WAIT.
  - WAIT: wrt=0. Stay until done=1. The stale done from the previous transaction is never sampled, because the monarch clears it on the ISSUE edge.
  - On done in WAIT:
    - idx 0: cmd_idx=1, go to ISSUE.
    - idx 1: ready<=1, go to IDLE.
    - idx 2: capture rd_data[7:0] into the low holding register; cmd_idx=3; go to ISSUE.
    - idx 3: sample <= {rd_data[7:0], low_hold}; vld=1 for exactly that next cycle; go to IDLE.
  - IDLE: on int_rise, cmd_idx=2 and go to ISSUE on the next edge. Otherwise hold.
- Back-to-back transactions: minimum gap between the done rise and the next wrt is 1 clock.
- Overrun:
  - int_rise while state is ISSUE or WAIT with cmd_idx>=2 sets ovr<=1. That edge is dropped, not queued.
  - int_rise before ready is ignored and does not set ovr.
  - clr_ovr=1 clears ovr. If clr_ovr and an overrun edge occur in the same cycle, set wins.
- sample holds its value between reads. vld is never high for two consecutive cycles.
- Reset mid-transaction: wrt and all outputs return to reset values immediately. The sequencer restarts from STARTUP; the SPI transaction in flight is abandoned (its monarch is reset by the same system reset).
- Illegal/unused state encoding: go to STARTUP.

Test Plan:
- Power-up (STARTUP_CYC=8; monarch model returns done 40 clocks after wrt): first wrt occurs 8 clocks after rst falls with wt_data=16'h0D02. Second wrt carries 16'h1062. ready rises the clock after the second done. Exactly 2 wrt pulses in total.
- Single read after ready: INT rises; rd_data returns 16'h00A5 then 16'h003C. Expect wt_data 16'hA200 then 16'hA300, then sample=16'h3CA5 with a single-cycle vld and ovr=0.
- Overrun: a second INT edge arrives while the RD_H transaction is in WAIT. Expect ovr=1, no extra wrt, sample updated once. Pulse clr_ovr: ovr=0 the next clock.
- INT before ready: toggle INT during STARTUP and init. Expect no read commands, ovr=0, vld never asserted.
- Stale done: monarch model holds done=1 through IDLE. Expect no early advance: after int_rise exactly one wrt, then the sequencer waits for a fresh done rise before the second wrt.
- Reset mid-read: assert rst during the RD_L WAIT. Expect wrt=0, ready=0, sample=16'h0000, vld=0 asynchronously. After release, the init sequence repeats with 16'h0D02 first.
